// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end.
//  - BR_* : 3-bit branch operation encodings driven by the controller.
//  - state_e : PC/fetch FSM states (2-bit).
//  - DEFAULT_RESET_VECTOR : default PC after reset.
package mips_pkg;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLT  = 3'b011;
  localparam logic [2:0] BR_BGT  = 3'b100;
  localparam logic [2:0] BR_J    = 3'b101;
  localparam logic [2:0] BR_JR   = 3'b110;
  localparam logic [2:0] BR_JAL  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_ERR   = 2'd3
  } state_e;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation (purely combinational).
//  branch_op  in  3  operation encoding (mips_pkg::BR_*)
//  zero/lt/gt in  1  ALU result flags
//  taken      out 1  control transfer happens
// Macro BRANCH_LINK_EN: when defined, BR_JAL is an unconditional jump; otherwise never taken.
module branch_cond
  import mips_pkg::*;
(
  input  logic [2:0] branch_op,
  input  logic       zero,
  input  logic       lt,
  input  logic       gt,
  output logic       taken
);

  // lt/gt are unreliable on equal operands, so they are qualified by ~zero.
  always_comb begin
    taken = 1'b0;
    case (branch_op)
      BR_BEQ:  taken = zero;
      BR_BNE:  taken = ~zero;
      BR_BLT:  taken = lt & ~zero;
      BR_BGT:  taken = gt & ~zero;
      BR_J:    taken = 1'b1;
      BR_JR:   taken = 1'b1;
`ifdef BRANCH_LINK_EN
      BR_JAL:  taken = 1'b1;
`endif
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Program counter and branch resolution stage.
// Fetches one instruction per req/ack handshake, then resolves the branch in EXEC and
// commits the next PC when not stalled.
//  clk, rst_n        clock / async active-low reset
//  imem_req/imem_ack fetch handshake (req high exactly in FETCH)
//  stall             hold the instruction in EXEC
//  branch_op, zero, lt, gt, imm_off, jump_target, jr_addr  branch inputs
//  pc, pc_plus4      current instruction address and its successor
//  instr_valid       high in EXEC
//  branch_taken      EXEC only: next PC differs from pc_plus4
//  fetch_err         sticky ack-timeout flag
//  link_we/link_data (BRANCH_LINK_EN only) JAL return address write
// Macro BRANCH_LINK_EN enables JAL (op 111) and the link ports.
module branch_pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int unsigned ACK_TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic        stall,
  input  logic [2:0]  branch_op,
  input  logic        zero,
  input  logic        lt,
  input  logic        gt,
  input  logic [31:0] imm_off,
  input  logic [25:0] jump_target,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        branch_taken,
  output logic        fetch_err
`ifdef BRANCH_LINK_EN
  ,
  output logic        link_we,
  output logic [31:0] link_data
`endif
);

  localparam int unsigned CntW = $clog2(ACK_TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(ACK_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     next_pc, branch_target, jump_addr;
  logic            cond_taken;

  branch_cond u_branch_cond (
    .branch_op (branch_op),
    .zero      (zero),
    .lt        (lt),
    .gt        (gt),
    .taken     (cond_taken)
  );

  assign pc            = pc_q;
  assign pc_plus4      = pc_q + 32'd4;
  assign branch_target = pc_plus4 + (imm_off << 2);
  assign jump_addr     = {pc_plus4[31:28], jump_target, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    case (branch_op)
      BR_BEQ, BR_BNE, BR_BLT, BR_BGT: if (cond_taken) next_pc = branch_target;
      BR_J:    next_pc = jump_addr;
      BR_JR:   next_pc = jr_addr & ~32'h3;
`ifdef BRANCH_LINK_EN
      BR_JAL:  next_pc = jump_addr;
`endif
      default: next_pc = pc_plus4;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_d         = pc_q;
    imem_req     = 1'b0;
    instr_valid  = 1'b0;
    branch_taken = 1'b0;
    fetch_err    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        // An ack on the last allowed cycle still wins over the timeout.
        if (imem_ack) begin
          cnt_d   = '0;
          state_d = S_EXEC;
        end else if (cnt_q == CntLast) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EXEC: begin
        instr_valid  = 1'b1;
        branch_taken = cond_taken;
        if (!stall) begin
          pc_d    = next_pc;
          state_d = S_FETCH;
        end
      end
      S_ERR: begin
        fetch_err = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef BRANCH_LINK_EN
  assign link_we   = (state_q == S_EXEC) && !stall && (branch_op == BR_JAL);
  assign link_data = pc_plus4;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed testbench for branch_pc_unit (RESET_VECTOR=0x100, ACK_TIMEOUT=4).
module tb_branch_pc_unit;
  import mips_pkg::*;

  logic        clk, rst_n, imem_req, imem_ack, stall;
  logic [2:0]  branch_op;
  logic        zero, lt, gt;
  logic [31:0] imm_off, jr_addr, pc, pc_plus4;
  logic [25:0] jump_target;
  logic        instr_valid, branch_taken, fetch_err;
`ifdef BRANCH_LINK_EN
  logic        link_we;
  logic [31:0] link_data;
`endif

  int n_cmp = 0;
  int n_err = 0;

  branch_pc_unit #(
    .RESET_VECTOR (32'h0000_0100),
    .ACK_TIMEOUT  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .stall        (stall),
    .branch_op    (branch_op),
    .zero         (zero),
    .lt           (lt),
    .gt           (gt),
    .imm_off      (imm_off),
    .jump_target  (jump_target),
    .jr_addr      (jr_addr),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .instr_valid  (instr_valid),
    .branch_taken (branch_taken),
    .fetch_err    (fetch_err)
`ifdef BRANCH_LINK_EN
    ,
    .link_we      (link_we),
    .link_data    (link_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; leave the sample point 2 ns after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Entered in FETCH: ack, run the instruction in EXEC without stall, land in FETCH.
  task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                           input logic l, input logic g, input logic [31:0] imm,
                           input logic [25:0] jt, input logic [31:0] jra,
                           input logic exp_taken, input logic [31:0] exp_pc);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    branch_op = op; zero = z; lt = l; gt = g;
    imm_off = imm; jump_target = jt; jr_addr = jra; stall = 1'b0;
    #1;
    check_eq({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
    check_eq({tag, ".taken"}, {31'd0, branch_taken}, {31'd0, exp_taken});
    step();
    check_eq({tag, ".pc"}, pc, exp_pc);
    check_eq({tag, ".req"}, {31'd0, imem_req}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; stall = 1'b0; branch_op = BR_NONE;
    zero = 1'b0; lt = 1'b0; gt = 1'b0; imm_off = '0; jump_target = '0; jr_addr = '0;
    #12;
    // T1 reset
    check_eq("rst.pc", pc, 32'h100);
    check_eq("rst.req", {31'd0, imem_req}, 32'd0);
    check_eq("rst.valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst.err", {31'd0, fetch_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("idle.req", {31'd0, imem_req}, 32'd0);
    step();
    check_eq("fetch.req", {31'd0, imem_req}, 32'd1);
    check_eq("fetch.valid", {31'd0, instr_valid}, 32'd0);

    // T2 sequential
    run_instr("seq0", BR_NONE, 0, 0, 0, 0, 0, 0, 1'b0, 32'h104);
    check_eq("seq0.valid_low", {31'd0, instr_valid}, 32'd0);
    run_instr("seq1", BR_NONE, 0, 0, 0, 0, 0, 0, 1'b0, 32'h108);

    // T3 BEQ
    run_instr("jr200a", BR_JR, 0, 0, 0, 0, 0, 32'h200, 1'b1, 32'h200);
    run_instr("beq_t", BR_BEQ, 1, 0, 0, 32'hFFFF_FFFE, 0, 0, 1'b1, 32'h1FC);
    run_instr("jr200b", BR_JR, 0, 0, 0, 0, 0, 32'h200, 1'b1, 32'h200);
    run_instr("beq_n", BR_BEQ, 0, 0, 0, 32'hFFFF_FFFE, 0, 0, 1'b0, 32'h204);

    // T4 BLT with stale lt, other conditions, JR alignment, J
    run_instr("blt_eq", BR_BLT, 1, 1, 0, 32'd4, 0, 0, 1'b0, 32'h208);
    run_instr("blt_t", BR_BLT, 0, 1, 0, 32'd4, 0, 0, 1'b1, 32'h21C);
    run_instr("bne_t", BR_BNE, 0, 0, 0, 32'd1, 0, 0, 1'b1, 32'h224);
    run_instr("bgt_eq", BR_BGT, 1, 0, 1, 32'd8, 0, 0, 1'b0, 32'h228);
    run_instr("bgt_t", BR_BGT, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 1'b1, 32'h228);
    run_instr("jr403", BR_JR, 0, 0, 0, 0, 0, 32'h403, 1'b1, 32'h400);
    run_instr("j", BR_J, 0, 0, 0, 0, 26'h123, 0, 1'b1, 32'h48C);

    // T6 JAL (or reserved op when the link feature is off)
    run_instr("jr1000", BR_JR, 0, 0, 0, 0, 0, 32'h1000, 1'b1, 32'h1000);
`ifdef BRANCH_LINK_EN
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    branch_op = BR_JAL; jump_target = 26'h456; stall = 1'b0;
    #1;
    check_eq("jal.we", {31'd0, link_we}, 32'd1);
    check_eq("jal.data", link_data, 32'h1004);
    check_eq("jal.taken", {31'd0, branch_taken}, 32'd1);
    step();
    check_eq("jal.pc", pc, 32'h1158);
    check_eq("jal.we_low", {31'd0, link_we}, 32'd0);
`else
    run_instr("rsv", BR_JAL, 1, 1, 1, 32'd4, 26'h456, 0, 1'b0, 32'h1004);
`endif

    // Wrap at the top of the address space
    run_instr("jrtop", BR_JR, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC);
    run_instr("wrap", BR_NONE, 0, 0, 0, 0, 0, 0, 1'b0, 32'h0);

    // T5 stall: pc held, branch_taken follows live flags
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    branch_op = BR_BEQ; zero = 1'b1; imm_off = 32'd3; stall = 1'b1;
    #1;
    check_eq("stall.taken1", {31'd0, branch_taken}, 32'd1);
    step();
    check_eq("stall.pc1", pc, 32'h0);
    check_eq("stall.valid1", {31'd0, instr_valid}, 32'd1);
    zero = 1'b0;
    #1;
    check_eq("stall.taken0", {31'd0, branch_taken}, 32'd0);
    step();
    step();
    check_eq("stall.pc3", pc, 32'h0);
    check_eq("stall.valid3", {31'd0, instr_valid}, 32'd1);
    zero = 1'b1; stall = 1'b0;
    step();
    check_eq("stall.commit", pc, 32'h10);

    // Ack arriving on the last allowed cycle wins
    branch_op = BR_NONE; zero = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_eq("limit.req", {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    check_eq("limit.valid", {31'd0, instr_valid}, 32'd1);
    check_eq("limit.err", {31'd0, fetch_err}, 32'd0);
    step();
    check_eq("limit.pc", pc, 32'h14);

    // Timeout: 4 FETCH cycles without ack
    for (int i = 0; i < 3; i++) step();
    check_eq("to.req3", {31'd0, imem_req}, 32'd1);
    check_eq("to.err3", {31'd0, fetch_err}, 32'd0);
    step();
    check_eq("to.err", {31'd0, fetch_err}, 32'd1);
    check_eq("to.req", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b1;
    step();
    step();
    check_eq("to.sticky", {31'd0, fetch_err}, 32'd1);
    check_eq("to.valid", {31'd0, instr_valid}, 32'd0);
    check_eq("to.pc", pc, 32'h14);
    imem_ack = 1'b0;

    // Async reset clears the fault
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst2.pc", pc, 32'h100);
    check_eq("rst2.err", {31'd0, fetch_err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
